// File: rtl/bpb_update_arbiter.sv
// Buffers up to two resolved-branch updates per cycle in an in-order FIFO and
// drains one per non-stalled cycle onto the single BPB write port.
module bpb_update_arbiter #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DROP_W = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    stall,
    input  logic [1:0]              commit_valid,
    input  logic [1:0][31:0]        commit_pc,
    input  logic [1:0]              commit_taken,
    output logic                    wen,
    output logic [31:0]             pc_commit,
    output logic                    taken_commit,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full,
    output logic [DROP_W-1:0]       drop_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [32:0]        mem_q [DEPTH];
    logic [AW-1:0]      head_q, head_d;
    logic [AW-1:0]      tail_q, tail_d;
    logic [AW-1:0]      tail_nx;
    logic [CW-1:0]      count_q, count_d;
    logic [DROP_W-1:0]  drop_q, drop_d;

    logic               deq;
    logic [CW-1:0]      space;
    logic [1:0]         n_in, n_acc, n_drop;
    logic [32:0]        wr0, wr1;
    logic [DROP_W:0]    drop_sum;

    assign wen          = (count_q != '0);
    assign pc_commit    = wen ? mem_q[head_q][32:1] : '0;
    assign taken_commit = wen ? mem_q[head_q][0]    : 1'b0;
    assign count        = count_q;
    assign full         = (count_q == CW'(DEPTH));
    assign drop_count   = drop_q;

    assign deq     = wen & ~stall;
    assign space   = CW'(DEPTH) - count_q + {{(CW-1){1'b0}}, deq};
    assign n_in    = {1'b0, commit_valid[0]} + {1'b0, commit_valid[1]};
    assign tail_nx = tail_q + AW'(1);

    // Compaction: the first accepted entry is slot 0 if valid, otherwise slot 1;
    // a second entry only exists when both slots are valid and both fit.
    assign wr0 = commit_valid[0] ? {commit_pc[0], commit_taken[0]}
                                 : {commit_pc[1], commit_taken[1]};
    assign wr1 = {commit_pc[1], commit_taken[1]};

    always_comb begin
        n_acc = n_in;
        if (CW'(n_in) > space) begin
            n_acc = space[1:0];
        end
        n_drop   = n_in - n_acc;
        head_d   = head_q + AW'(deq);
        tail_d   = tail_q + AW'(n_acc);
        count_d  = count_q + CW'(n_acc) - CW'(deq);
        drop_sum = {1'b0, drop_q} + (DROP_W+1)'(n_drop);
        drop_d   = drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            drop_q  <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            drop_q  <= drop_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            if (n_acc != 2'd0) begin
                mem_q[tail_q] <= wr0;
            end
            if (n_acc == 2'd2) begin
                mem_q[tail_nx] <= wr1;
            end
        end
    end

endmodule

// File: tb/tb_bpb_update_arbiter.sv
// Self-checking bench for bpb_update_arbiter: directed scenarios plus randomized
// traffic compared against a queue-based reference model.
module tb_bpb_update_arbiter;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned DW    = 5;
    localparam int          MAXD  = (1 << DW) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             stall;
    logic [1:0]       commit_valid;
    logic [1:0][31:0] commit_pc;
    logic [1:0]       commit_taken;
    logic             wen;
    logic [31:0]      pc_commit;
    logic             taken_commit;
    logic [2:0]       count;
    logic             full;
    logic [DW-1:0]    drop_count;

    int checks = 0;
    int errors = 0;

    // Reference model: a plain queue of {pc, taken} and an integer drop counter.
    logic [32:0] mq[$];
    int          mdrop = 0;

    bpb_update_arbiter #(.DEPTH(DEPTH), .DROP_W(DW)) dut (
        .clk(clk), .reset(reset), .stall(stall),
        .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_taken(commit_taken),
        .wen(wen), .pc_commit(pc_commit), .taken_commit(taken_commit),
        .count(count), .full(full), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    function automatic logic exp_wen();
        return mq.size() != 0;
    endfunction

    function automatic logic [31:0] exp_pc();
        return (mq.size() != 0) ? mq[0][32:1] : 32'h0;
    endfunction

    function automatic logic exp_taken();
        return (mq.size() != 0) ? mq[0][0] : 1'b0;
    endfunction

    // Advance one clock; the model consumes the inputs that were present at the edge.
    task automatic tick();
        @(posedge clk);
        if (!reset) begin
            mq.delete();
            mdrop = 0;
        end else begin
            if (mq.size() != 0 && !stall) void'(mq.pop_front());
            for (int s = 0; s < 2; s++) begin
                if (commit_valid[s]) begin
                    if (mq.size() < DEPTH) mq.push_back({commit_pc[s], commit_taken[s]});
                    else if (mdrop < MAXD) mdrop++;
                end
            end
        end
        #1;
    endtask

    task automatic set_in(input logic [1:0] v, input logic [31:0] p0, input logic t0,
                          input logic [31:0] p1, input logic t1, input logic st);
        commit_valid    = v;
        commit_pc[0]    = p0;
        commit_taken[0] = t0;
        commit_pc[1]    = p1;
        commit_taken[1] = t1;
        stall           = st;
    endtask

    task automatic idle(input logic st);
        set_in(2'b00, 32'h0, 1'b0, 32'h0, 1'b0, st);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        idle(1'b0);
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (wen !== 1'b0 || count !== 3'd0 || full !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: wen=%b count=%0d full=%b, want 0 0 0", wen, count, full);
        end
        checks++;
        if (pc_commit !== 32'h0 || taken_commit !== 1'b0 || drop_count !== '0) begin
            errors++;
            $display("FAIL reset_data: pc=%h taken=%b drop=%0d, want 0", pc_commit, taken_commit, drop_count);
        end
    endtask

    task automatic test_single();
        set_in(2'b01, 32'h0040_0010, 1'b1, 32'h0, 1'b0, 1'b0);
        tick();
        idle(1'b0);
        checks++;
        if (wen !== 1'b1 || pc_commit !== 32'h0040_0010 || taken_commit !== 1'b1) begin
            errors++;
            $display("FAIL single_head: wen=%b pc=%h taken=%b, want 1 00400010 1", wen, pc_commit, taken_commit);
        end
        tick();
        checks++;
        if (wen !== 1'b0 || count !== 3'd0) begin
            errors++;
            $display("FAIL single_drain: wen=%b count=%0d, want 0 0", wen, count);
        end
    endtask

    task automatic test_dual();
        logic [31:0] want_pc[3]  = '{32'h100, 32'h200, 32'h0};
        logic [2:0]  want_cnt[3] = '{3'd2, 3'd1, 3'd0};
        set_in(2'b11, 32'h100, 1'b1, 32'h200, 1'b0, 1'b0);
        tick();
        idle(1'b0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (pc_commit !== want_pc[i] || count !== want_cnt[i]) begin
                errors++;
                $display("FAIL dual_seq[%0d]: pc=%h count=%0d, want %h %0d", i, pc_commit, count, want_pc[i], want_cnt[i]);
            end
            tick();
        end
    endtask

    task automatic test_stall_fill();
        logic [2:0] want_cnt[3] = '{3'd2, 3'd4, 3'd4};
        for (int i = 0; i < 3; i++) begin
            set_in(2'b11, 32'h1000 + 32'(i*8), 1'b1, 32'h1004 + 32'(i*8), 1'b0, 1'b1);
            tick();
            checks++;
            if (count !== want_cnt[i] || pc_commit !== 32'h1000) begin
                errors++;
                $display("FAIL stall_fill[%0d]: count=%0d pc=%h, want %0d 1000", i, count, pc_commit, want_cnt[i]);
            end
        end
        checks++;
        if (drop_count !== 5'd2 || full !== 1'b1) begin
            errors++;
            $display("FAIL stall_drop: drop=%0d full=%b, want 2 1", drop_count, full);
        end
    endtask

    task automatic test_full_deq();
        set_in(2'b11, 32'hA0, 1'b1, 32'hB0, 1'b1, 1'b0);
        tick();
        idle(1'b0);
        checks++;
        if (count !== 3'd4 || drop_count !== 5'd3 || pc_commit !== 32'h1004) begin
            errors++;
            $display("FAIL full_deq: count=%0d drop=%0d pc=%h, want 4 3 1004", count, drop_count, pc_commit);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (wen !== exp_wen() || pc_commit !== exp_pc() || taken_commit !== exp_taken()) begin
                errors++;
                $display("FAIL full_drain[%0d]: wen=%b pc=%h t=%b, want %b %h %b", i, wen, pc_commit, taken_commit, exp_wen(), exp_pc(), exp_taken());
            end
        end
        checks++;
        if (wen !== 1'b0) begin
            errors++;
            $display("FAIL full_empty: wen=%b, want 0 (0xA0 should have been last)", wen);
        end
    endtask

    task automatic test_slot1_only();
        set_in(2'b10, 32'hDEAD, 1'b1, 32'h300, 1'b0, 1'b0);
        tick();
        idle(1'b1);
        checks++;
        if (wen !== 1'b1 || pc_commit !== 32'h300 || taken_commit !== 1'b0 || count !== 3'd1 || drop_count !== 5'd3) begin
            errors++;
            $display("FAIL slot1_only: wen=%b pc=%h t=%b count=%0d drop=%0d, want 1 300 0 1 3", wen, pc_commit, taken_commit, count, drop_count);
        end
        idle(1'b0);
        tick();
    endtask

    task automatic test_wrap();
        logic [31:0] sent[$];
        logic [31:0] got[$];
        int          cyc = 0;
        while ((sent.size() < 10 || mq.size() != 0) && cyc < 60) begin
            if (sent.size() < 10 && mq.size() < DEPTH) begin
                set_in(2'b01, 32'h5000 + 32'(sent.size()), sent.size() % 2 == 1, 32'h0, 1'b0, cyc % 2 == 1);
                sent.push_back(32'h5000 + 32'(sent.size()));
            end else begin
                idle(cyc % 2 == 1);
            end
            if (wen && !stall) got.push_back(pc_commit);
            tick();
            cyc++;
        end
        idle(1'b0);
        checks++;
        if (got.size() != 10 || drop_count !== 5'(mdrop)) begin
            errors++;
            $display("FAIL wrap_count: drained=%0d drop=%0d, want 10 %0d", got.size(), drop_count, mdrop);
        end
        for (int i = 0; i < got.size() && i < 10; i++) begin
            checks++;
            if (got[i] !== sent[i]) begin
                errors++;
                $display("FAIL wrap_order[%0d]: pc=%h, want %h", i, got[i], sent[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            set_in(2'b11, 32'h7000 + 32'(i*8), 1'b0, 32'h7004 + 32'(i*8), 1'b1, 1'b1);
            tick();
        end
        idle(1'b0);
        tick();
        checks++;
        if (count !== 3'd3 || drop_count === 5'd0) begin
            errors++;
            $display("FAIL reset_mid_setup: count=%0d drop=%0d, want 3 nonzero", count, drop_count);
        end
        reset = 1'b0;
        set_in(2'b11, 32'h9000, 1'b1, 32'h9004, 1'b1, 1'b0);
        tick();
        reset = 1'b1;
        idle(1'b0);
        checks++;
        if (wen !== 1'b0 || count !== 3'd0 || drop_count !== 5'd0) begin
            errors++;
            $display("FAIL reset_mid: wen=%b count=%0d drop=%0d, want 0 0 0", wen, count, drop_count);
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 22; i++) begin
            set_in(2'b11, 32'(i), 1'b0, 32'(i + 100), 1'b1, 1'b1);
            tick();
            checks++;
            if (drop_count !== 5'(mdrop)) begin
                errors++;
                $display("FAIL sat_step[%0d]: drop=%0d, want %0d", i, drop_count, mdrop);
            end
        end
        checks++;
        if (drop_count !== 5'd31) begin
            errors++;
            $display("FAIL sat_final: drop=%0d, want 31", drop_count);
        end
        idle(1'b0);
        for (int i = 0; i < 5; i++) tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 59) != 0);
            set_in(2'($urandom), $urandom, 1'($urandom), $urandom, 1'($urandom),
                   $urandom_range(0, 2) == 0);
            tick();
            checks++;
            if (wen !== exp_wen() || pc_commit !== exp_pc() || taken_commit !== exp_taken() ||
                count !== 3'(mq.size()) || full !== (mq.size() == DEPTH) || drop_count !== 5'(mdrop)) begin
                errors++;
                $display("FAIL random[%0d]: wen=%b pc=%h t=%b cnt=%0d full=%b drop=%0d, want %b %h %b %0d %b %0d",
                         i, wen, pc_commit, taken_commit, count, full, drop_count,
                         exp_wen(), exp_pc(), exp_taken(), mq.size(), mq.size() == DEPTH, mdrop);
            end
        end
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        idle(1'b0);
        test_reset();
        test_single();
        test_dual();
        test_stall_fill();
        test_full_deq();
        test_slot1_only();
        test_wrap();
        test_reset_mid();
        do_reset();
        test_saturation();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
